// File: rtl/rs_alu_pkg.sv
// rtl/rs_alu_pkg.sv - segment sizing helpers shared by the segmented pipelined adder
package rs_alu_pkg;

  localparam int MAX_CARRY_CHAIN = 64;

  function automatic int nseg_calc(input int width, input int seg_w);
    return (width + seg_w - 1) / seg_w;
  endfunction

  // Every segment is seg_w bits except the last, which takes whatever is left over.
  function automatic int seg_width(input int width, input int seg_w, input int k);
    return (k == nseg_calc(width, seg_w) - 1) ? width - k * seg_w : seg_w;
  endfunction

endpackage

// File: rtl/rs_alu_seg.sv
// rtl/rs_alu_seg.sv - combinational ripple-carry segment; also exposes the carry into its MSB
module rs_alu_seg #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic [W-1:0] prop,
  output logic         cout,
  output logic         cmsb
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_adder_carry
    assign prop[i]  = a[i] ^ b[i];
    assign sum[i]   = prop[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (prop[i] & c[i]);
  end

  assign cout = c[W];
  assign cmsb = c[W - 1];

endmodule

// File: rtl/rs_pipe_alu.sv
// rtl/rs_pipe_alu.sv - pipelined adder, one carry segment per stage, valid/ready handshake
module rs_pipe_alu
  import rs_alu_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int SEG_WIDTH = 16,
  parameter bit SIGNED    = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  input  logic             BI,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] X,
  output logic             CO,
  output logic             OV,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);

  localparam int NSEG = nseg_calc(WIDTH, SEG_WIDTH);

  logic hold;

  assign hold     = g_stage[NSEG-1].v_q && !OUT_READY;
  assign IN_READY = !hold;

  // ay_q carries unprocessed A bits above the current segment and finished Y bits below it;
  // bx_q does the same for B' and X, so each word is fully consumed as it moves down the pipe.
  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    localparam int LO = k * SEG_WIDTH;
    localparam int SW = seg_width(WIDTH, SEG_WIDTH, k);

    logic [WIDTH-1:0] ay_in, bx_in, ay_nxt, bx_nxt, ay_q, bx_q;
    logic             cin, vin, c_q, v_q;
    logic [SW-1:0]    sum, prop;
    logic             cout, cmsb;

    if (k == 0) begin : g_first
      assign ay_in = A;
      assign bx_in = BI ? ~B : B;
      assign cin   = CI;
      assign vin   = IN_VALID;
    end else begin : g_next
      assign ay_in = g_stage[k-1].ay_q;
      assign bx_in = g_stage[k-1].bx_q;
      assign cin   = g_stage[k-1].c_q;
      assign vin   = g_stage[k-1].v_q;
    end

    rs_alu_seg #(.W(SW)) u_seg (
      .a    (ay_in[LO +: SW]),
      .b    (bx_in[LO +: SW]),
      .cin  (cin),
      .sum  (sum),
      .prop (prop),
      .cout (cout),
      .cmsb (cmsb)
    );

    always_comb begin
      ay_nxt            = ay_in;
      ay_nxt[LO +: SW]  = sum;
      bx_nxt            = bx_in;
      bx_nxt[LO +: SW]  = prop;
    end

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        ay_q <= '0;
        bx_q <= '0;
        c_q  <= 1'b0;
        v_q  <= 1'b0;
      end else if (!hold) begin
        ay_q <= ay_nxt;
        bx_q <= bx_nxt;
        c_q  <= cout;
        v_q  <= vin;
      end
    end

    // Only the top segment's MSB carry matters for signed overflow.
    if (k == NSEG - 1) begin : g_ov
      logic ov_q;
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          ov_q <= 1'b0;
        end else if (!hold) begin
          ov_q <= SIGNED ? (cmsb ^ cout) : 1'b0;
        end
      end
    end else begin : g_no_ov
      logic cmsb_unused;
      assign cmsb_unused = cmsb;
    end
  end

  assign Y         = g_stage[NSEG-1].ay_q;
  assign X         = g_stage[NSEG-1].bx_q;
  assign CO        = g_stage[NSEG-1].c_q;
  assign OV        = g_stage[NSEG-1].g_ov.ov_q;
  assign OUT_VALID = g_stage[NSEG-1].v_q;

endmodule

// File: tb/tb_rs_pipe_alu.sv
// tb/tb_rs_pipe_alu.sv - directed self-checking bench for rs_pipe_alu (64-bit signed, 40-bit unsigned)
module tb_rs_pipe_alu;

  typedef struct packed {
    logic [63:0] y;
    logic [63:0] x;
    logic        co;
    logic        ov;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] a, b, y, x;
  logic        ci, bi, in_valid, in_ready, co, ov, out_valid, out_ready;
  logic [39:0] a40, b40, y40, x40;
  logic        ci40, bi40, in_valid40, in_ready40, co40, ov40, out_valid40, out_ready40;

  int   tests = 0;
  int   fails = 0;
  int   nin   = 0;
  int   nout  = 0;
  int   nmark;
  exp_t q[$];

  always #5 clk = ~clk;

  rs_pipe_alu #(.WIDTH(64), .SEG_WIDTH(16), .SIGNED(1'b1)) u64 (
    .CLK(clk), .RST(rst), .A(a), .B(b), .CI(ci), .BI(bi),
    .IN_VALID(in_valid), .IN_READY(in_ready), .Y(y), .X(x), .CO(co), .OV(ov),
    .OUT_VALID(out_valid), .OUT_READY(out_ready)
  );

  rs_pipe_alu #(.WIDTH(40), .SEG_WIDTH(16), .SIGNED(1'b0)) u40 (
    .CLK(clk), .RST(rst), .A(a40), .B(b40), .CI(ci40), .BI(bi40),
    .IN_VALID(in_valid40), .IN_READY(in_ready40), .Y(y40), .X(x40), .CO(co40), .OV(ov40),
    .OUT_VALID(out_valid40), .OUT_READY(out_ready40)
  );

  function automatic exp_t model(input logic [63:0] ma, input logic [63:0] mb,
                                 input logic mci, input logic mbi);
    logic [63:0] bp;
    logic [64:0] s;
    exp_t        e;
    bp   = mbi ? ~mb : mb;
    s    = {1'b0, ma} + {1'b0, bp} + {64'd0, mci};
    e.y  = s[63:0];
    e.co = s[64];
    e.x  = ma ^ bp;
    e.ov = (ma[63] == bp[63]) && (s[63] != ma[63]);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: score the output side at the falling edge, then step past the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_out_valid", {63'd0, out_valid}, 64'd0);
      end else if (out_ready) begin
        e = q.pop_front();
        nout++;
        chk("sb_y", y, e.y);
        chk("sb_x", x, e.x);
        chk("sb_co", {63'd0, co}, {63'd0, e.co});
        chk("sb_ov", {63'd0, ov}, {63'd0, e.ov});
      end
    end
    if (in_valid && in_ready) begin
      q.push_back(model(a, b, ci, bi));
      nin++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic op64(input logic [63:0] ta, input logic [63:0] tb_, input logic tci,
                      input logic tbi, input logic [63:0] ey, input logic eco,
                      input logic eov, input string tag);
    a = ta; b = tb_; ci = tci; bi = tbi; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      chk({tag, "_latency"}, {63'd0, out_valid}, {63'd0, n == 4});
      if (n < 4) cycle();
    end
    chk({tag, "_y"}, y, ey);
    chk({tag, "_co"}, {63'd0, co}, {63'd0, eco});
    chk({tag, "_ov"}, {63'd0, ov}, {63'd0, eov});
    cycle();
  endtask

  initial begin
    rst = 1'b1;
    a = '0; b = '0; ci = 1'b0; bi = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a40 = '0; b40 = '0; ci40 = 1'b0; bi40 = 1'b0; in_valid40 = 1'b0; out_ready40 = 1'b1;

    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_y", y, 64'd0);
    chk("rst_x", x, 64'd0);
    chk("rst_co_ov", {62'd0, co, ov}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_w40_valid", {63'd0, out_valid40}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    op64(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, "ripple");
    op64(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, "sovf");
    op64(64'd5, 64'd3, 1'b1, 1'b1, 64'd2, 1'b1, 1'b0, "sub");

    // 40-bit instance: three stages, short top segment.
    a40 = 40'hFF_FFFF_FFFF; b40 = 40'd1; in_valid40 = 1'b1;
    cycle();
    in_valid40 = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      chk("w40_latency", {63'd0, out_valid40}, {63'd0, n == 3});
      if (n < 3) cycle();
    end
    chk("w40_y", {24'd0, y40}, 64'd0);
    chk("w40_x", {24'd0, x40}, 64'h00FF_FFFF_FFFE);
    chk("w40_co", {63'd0, co40}, 64'd1);
    chk("w40_ov", {63'd0, ov40}, 64'd0);
    cycle();
    chk("w40_bubble", {63'd0, out_valid40}, 64'd0);

    // Back-to-back random stream.
    nmark = nout;
    for (int i = 0; i < 100; i++) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      ci = 1'($urandom_range(0, 1)); bi = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    chk("stream_rate", 64'(nout - nmark), 64'd96);
    repeat (6) cycle();
    chk("stream_count", 64'(nout - nmark), 64'd100);
    chk("stream_drained", 64'(q.size()), 64'd0);

    // Stall with pipeline full, then release while still offering input.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      ci = 1'($urandom_range(0, 1)); bi = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      cycle();
      if (i >= 4) begin
        chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
        chk("stall_y_frozen", y, q[0].y);
        chk("stall_x_frozen", x, q[0].x);
      end
    end
    chk("stall_accepted", 64'(q.size()), 64'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      ci = 1'($urandom_range(0, 1)); bi = 1'($urandom_range(0, 1));
      cycle();
    end
    in_valid = 1'b0;
    repeat (8) cycle();
    chk("stall_drained", 64'(q.size()), 64'd0);
    chk("stall_in_eq_out", 64'(nout), 64'(nin));

    // Reset with three operations in flight, first one parked at the output.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 64'(i + 10); b = 64'(i + 20); ci = 1'b0; bi = 1'b0; in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    chk("pre_rst_out_valid", {63'd0, out_valid}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("async_rst_y", y, 64'd0);
    chk("async_rst_in_ready", {63'd0, in_ready}, 64'd1);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (6) cycle();
    chk("no_stale_after_rst", {63'd0, out_valid}, 64'd0);
    op64(64'h1234, 64'h1111, 1'b0, 1'b0, 64'h2345, 1'b0, 1'b0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
